// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and helpers for the audio tuning blocks
package audio_pkg;

  typedef enum logic {SEEK, MEASURE} state_t;

  localparam int PHASESIZE_DEFAULT = 16;
  // Edges from a period-closing crossing to the freq/valid update.
  localparam int DIV_LATENCY = PHASESIZE_DEFAULT + 2;

  function automatic int unsigned mid_scale(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

endpackage

// File: rtl/recip_divider.sv
// rtl/recip_divider.sv - restoring divider computing 2^PHASESIZE / divisor, one bit per edge
module recip_divider #(
  parameter int PHASESIZE = 16,
  parameter int CNTSIZE   = 16
) (
  input  logic                 lrclk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNTSIZE-1:0]   divisor,
  output logic                 busy,
  output logic                 done,
  output logic [PHASESIZE-1:0] quotient
);

  localparam int BW = $clog2(PHASESIZE + 1);

  logic [BW-1:0]      bitn;
  logic [CNTSIZE-1:0] div_r;
  logic [CNTSIZE-1:0] rem;
  logic [PHASESIZE:0] num;
  logic [PHASESIZE:0] quo;
  logic [CNTSIZE:0]   rem_sh;
  logic [CNTSIZE-1:0] trial;
  logic               fits;

  // The remainder stays below the divisor, so modular CNTSIZE-bit subtraction is exact.
  always_comb begin
    rem_sh = {rem, num[PHASESIZE]};
    fits   = rem_sh >= {1'b0, div_r};
    trial  = rem_sh[CNTSIZE-1:0] - div_r;
  end

  assign quotient = quo[PHASESIZE] ? '1 : quo[PHASESIZE-1:0];

  always_ff @(posedge lrclk or posedge reset) begin
    if (reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      bitn  <= '0;
      div_r <= '0;
      rem   <= '0;
      num   <= '0;
      quo   <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        div_r <= divisor;
        rem   <= '0;
        num   <= {1'b1, {PHASESIZE{1'b0}}};
        quo   <= '0;
        bitn  <= BW'(PHASESIZE);
        busy  <= 1'b1;
      end else if (busy) begin
        num <= {num[PHASESIZE-1:0], 1'b0};
        rem <= fits ? trial : rem_sh[CNTSIZE-1:0];
        quo <= {quo[PHASESIZE-1:0], fits};
        if (bitn == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          bitn <= bitn - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/frequency_estimator.sv
// rtl/frequency_estimator.sv - pitch tracker reporting the input fundamental as a phase increment
module frequency_estimator
  import audio_pkg::*;
#(
  parameter int BITSIZE   = 24,
  parameter int PHASESIZE = 16,
  parameter int CNTSIZE   = 16,
  parameter int HYST      = 256
) (
  input  logic                 lrclk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [BITSIZE-1:0]   in,
  output logic [PHASESIZE-1:0] freq,
  output logic                 valid,
  output logic                 locked,
  output logic                 overflow
);

  localparam logic [BITSIZE-1:0] HI_TH   = BITSIZE'(mid_scale(BITSIZE) + HYST);
  localparam logic [BITSIZE-1:0] LO_TH   = BITSIZE'(mid_scale(BITSIZE) - HYST);
  localparam logic [CNTSIZE-1:0] CNT_MAX = '1;

  state_t               state;
  logic                 high;
  logic [CNTSIZE-1:0]   cnt;
  logic [CNTSIZE-1:0]   pend;
  logic                 pend_valid;
  logic                 inflight;
  logic                 crossing, period_new, idle;
  logic                 launch_pend, launch_direct, div_start;
  logic [CNTSIZE-1:0]   div_divisor;
  logic                 div_busy, div_done;
  logic [PHASESIZE-1:0] div_quotient;

  assign crossing      = !high && (in >= HI_TH);
  assign period_new    = crossing && (state == MEASURE);
  assign idle          = !inflight && !div_busy;
  // A waiting period always launches before a freshly measured one.
  assign launch_pend   = pend_valid && idle;
  assign launch_direct = period_new && idle && !pend_valid;
  assign div_start     = enable && (launch_pend || launch_direct);
  assign div_divisor   = launch_pend ? pend : cnt;

  recip_divider #(.PHASESIZE(PHASESIZE), .CNTSIZE(CNTSIZE)) u_div (
    .lrclk    (lrclk),
    .reset    (reset),
    .start    (div_start),
    .abort    (!enable),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge lrclk or posedge reset) begin
    if (reset) begin
      state      <= SEEK;
      high       <= 1'b0;
      cnt        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      inflight   <= 1'b0;
      freq       <= '0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      overflow   <= 1'b0;
    end else if (!enable) begin
      state      <= SEEK;
      high       <= 1'b0;
      cnt        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      inflight   <= 1'b0;
      freq       <= '0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      valid    <= 1'b0;
      overflow <= 1'b0;
      high     <= crossing ? 1'b1 : (high && (in < LO_TH)) ? 1'b0 : high;

      if (crossing)
        cnt <= CNTSIZE'(1);
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;

      case (state)
        SEEK:    if (crossing) state <= MEASURE;
        MEASURE: if (!crossing && cnt == CNT_MAX) begin
          overflow <= 1'b1;
          locked   <= 1'b0;
          state    <= SEEK;
        end
        default: state <= SEEK;
      endcase

      if (period_new && !launch_direct) begin
        pend       <= cnt;
        pend_valid <= 1'b1;
      end else if (launch_pend) begin
        pend_valid <= 1'b0;
      end

      if (div_start)
        inflight <= 1'b1;
      else if (div_done)
        inflight <= 1'b0;

      if (div_done) begin
        freq   <= div_quotient;
        valid  <= 1'b1;
        locked <= 1'b1;
      end
    end
  end

endmodule
